// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader for the PPU instruction memory: writes an incoming image
// sequentially, accumulates a big-endian word checksum and holds the CPU until done.
module imem_boot_loader #(
   parameter int ADDR_W      = 9,
   parameter int BYTE_W      = 8,
   parameter int HOLD_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BYTE_W-1:0] mem_wdata,
   output logic [ADDR_W:0]   byte_count,
   output logic [31:0]       checksum,
   output logic              cpu_run,
   output logic              done,
   output logic              error
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] HOLD = 3'd2;
   localparam logic [2:0] DONE = 3'd3;
   localparam logic [2:0] ERR  = 3'd4;

   localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
   localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       sum_q, sum_d;
   logic [31:0]       word_q, word_d;
   logic [1:0]        lane_q, lane_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BYTE_W-1:0] wdata_q, wdata_d;

   logic              accept;
   logic [7:0]        laneByte;
   logic [31:0]       merged;

   assign in_ready = (state_q == LOAD) && (count_q < DEPTH);
   assign accept   = in_valid && in_ready;
   assign laneByte = 8'(in_data);

   // First byte of each word lands in the top lane so the sum is over big-endian words.
   always_comb begin
      merged = word_q;
      case (lane_q)
         2'd0:    merged = word_q | {laneByte, 24'h0};
         2'd1:    merged = word_q | {8'h0, laneByte, 16'h0};
         2'd2:    merged = word_q | {16'h0, laneByte, 8'h0};
         default: merged = word_q | {24'h0, laneByte};
      endcase
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      sum_d   = sum_q;
      word_d  = word_q;
      lane_d  = lane_q;
      hold_d  = hold_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LOAD;
               count_d = '0;
               sum_d   = '0;
               word_d  = '0;
               lane_d  = '0;
            end
         end
         LOAD: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = count_q[ADDR_W-1:0];
               wdata_d = in_data;
               count_d = count_q + (ADDR_W+1)'(1);
               // A last byte on a partial word folds in the zero-padded word immediately.
               if (lane_q == 2'd3 || in_last) begin
                  sum_d  = sum_q + merged;
                  word_d = '0;
                  lane_d = '0;
               end else begin
                  word_d = merged;
                  lane_d = lane_q + 2'd1;
               end
               if (in_last) begin
                  state_d = HOLD;
                  hold_d  = '0;
               end
            end else if (in_valid && count_q == DEPTH) begin
               state_d = ERR;
            end
         end
         HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = DONE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
         sum_q   <= '0;
         word_q  <= '0;
         lane_q  <= '0;
         hold_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         sum_q   <= sum_d;
         word_q  <= word_d;
         lane_q  <= lane_d;
         hold_q  <= hold_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign byte_count = count_q;
   assign checksum   = sum_q;
   assign cpu_run    = (state_q == DONE);
   assign done       = (state_q == DONE);
   assign error      = (state_q == ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised bench for imem_boot_loader against a transaction-level image model
// (expected writes, checksum by arithmetic over the image, release timing).
module tb_imem_boot_loader;

   localparam int ADDR_W = 4;
   localparam int BYTE_W = 8;
   localparam int HOLD   = 4;
   localparam int DEPTH  = 16;

   typedef logic [7:0] byte_t;

   logic              clk;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic [BYTE_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [BYTE_W-1:0] mem_wdata;
   logic [ADDR_W:0]   byte_count;
   logic [31:0]       checksum;
   logic              cpu_run;
   logic              done;
   logic              error;

   int        checks   = 0;
   int        failures = 0;
   int        mCount;
   bit [31:0] mSum;

   imem_boot_loader #(.ADDR_W(ADDR_W), .BYTE_W(BYTE_W), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .byte_count(byte_count), .checksum(checksum),
      .cpu_run(cpu_run), .done(done), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL timeout got=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".in_ready"}, in_ready, 0);
      checkOutput({tag, ".mem_we"}, mem_we, 0);
      checkOutput({tag, ".mem_addr"}, mem_addr, 0);
      checkOutput({tag, ".mem_wdata"}, mem_wdata, 0);
      checkOutput({tag, ".byte_count"}, byte_count, 0);
      checkOutput({tag, ".checksum"}, checksum, 0);
      checkOutput({tag, ".cpu_run"}, cpu_run, 0);
      checkOutput({tag, ".done"}, done, 0);
      checkOutput({tag, ".error"}, error, 0);
   endtask

   // Start pulse from IDLE/DONE/ERR; a byte offered alongside it must not be taken.
   task automatic applyStart(input bit withValid);
      start    = 1'b1;
      in_valid = withValid;
      in_data  = 8'hAA;
      in_last  = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      mCount   = 0;
      mSum     = '0;
      checkOutput("start.mem_we", mem_we, 0);
      checkOutput("start.byte_count", byte_count, 0);
      checkOutput("start.checksum", checksum, 0);
      checkOutput("start.cpu_run", cpu_run, 0);
      checkOutput("start.done", done, 0);
      checkOutput("start.error", error, 0);
      checkOutput("start.in_ready", in_ready, 1);
   endtask

   task automatic applyStimulus(input byte_t img[$], input bit gaps, input bit noisyStart,
                                input bit withLast);
      int i;
      int tries;
      i     = 0;
      tries = 0;
      while (i < img.size()) begin
         bit v;
         bit isLast;
         v      = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (tries > 40) v = 1'b1;
         isLast = withLast && (i == img.size() - 1);
         tries++;
         in_valid = v;
         start    = noisyStart ? 1'($urandom_range(0, 1)) : 1'b0;
         if (v) begin
            in_data = img[i];
            in_last = isLast;
         end else begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
         end
         checkOutput("load.in_ready", in_ready, (mCount < DEPTH));
         tick();
         checkOutput("load.mem_we", mem_we, v);
         if (v) begin
            checkOutput("load.mem_addr", mem_addr, mCount);
            checkOutput("load.mem_wdata", mem_wdata, img[i]);
            mSum = mSum + (32'(img[i]) << (24 - 8 * (i % 4)));
            mCount++;
            i++;
         end
         checkOutput("load.byte_count", byte_count, mCount);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (withLast) begin
         checkOutput("hold.checksum", checksum, mSum);
         checkOutput("hold.cpu_run_entry", cpu_run, 0);
         for (int k = 1; k <= HOLD; k++) begin
            in_valid = 1'($urandom);
            start    = noisyStart ? 1'($urandom) : 1'b0;
            tick();
            checkOutput("hold.mem_we", mem_we, 0);
            checkOutput("hold.cpu_run", cpu_run, (k == HOLD));
            checkOutput("hold.done", done, (k == HOLD));
            checkOutput("hold.byte_count", byte_count, mCount);
         end
         start    = 1'b0;
         in_valid = 1'b0;
         checkOutput("done.checksum", checksum, mSum);
      end
   endtask

   initial begin
      byte_t img[$];
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      tick();
      tick();
      checkAllZero("reset");
      reset = 1'b1;
      tick();
      checkAllZero("idle");

      applyStart(1'b1);
      img = '{8'h3C, 8'h01, 8'h00, 8'h10, 8'h24, 8'h21, 8'h00, 8'h04};
      applyStimulus(img, 1'b0, 1'b0, 1'b1);
      checkOutput("img8.checksum", checksum, 32'h60220014);

      applyStart(1'b0);
      img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
      applyStimulus(img, 1'b1, 1'b0, 1'b1);
      checkOutput("img5.checksum", checksum, 32'h00020304);
      checkOutput("img5.byte_count", byte_count, 5);

      for (int r = 0; r < 8; r++) begin
         int len;
         applyStart(1'($urandom));
         len = (r == 0) ? DEPTH : $urandom_range(1, DEPTH);
         img = {};
         for (int b = 0; b < len; b++) img.push_back(8'($urandom));
         applyStimulus(img, 1'b1, 1'b1, 1'b1);
      end

      applyStart(1'b0);
      img = {};
      for (int b = 0; b < DEPTH; b++) img.push_back(8'($urandom));
      applyStimulus(img, 1'b1, 1'b1, 1'b0);
      checkOutput("full.in_ready", in_ready, 0);
      checkOutput("full.error", error, 0);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      in_last  = 1'b0;
      tick();
      in_valid = 1'b0;
      checkOutput("ovf.mem_we", mem_we, 0);
      checkOutput("ovf.error", error, 1);
      checkOutput("ovf.cpu_run", cpu_run, 0);
      checkOutput("ovf.done", done, 0);
      checkOutput("ovf.byte_count", byte_count, DEPTH);
      checkOutput("ovf.in_ready", in_ready, 0);
      tick();
      checkOutput("ovf.mem_we_hold", mem_we, 0);
      checkOutput("ovf.error_hold", error, 1);

      applyStart(1'b0);
      img = '{8'h11, 8'h22, 8'h33};
      applyStimulus(img, 1'b0, 1'b0, 1'b1);

      applyStart(1'b0);
      img = '{8'hDE, 8'hAD, 8'hBE};
      applyStimulus(img, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      checkAllZero("midreset");
      reset = 1'b1;
      tick();
      checkAllZero("midreset_idle");
      applyStart(1'b1);
      img = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h12, 8'h34};
      applyStimulus(img, 1'b1, 1'b0, 1'b1);
      checkOutput("restart.checksum", checksum, 32'hCAFEF00D + 32'h12340000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
